// File: rtl/vecrec_pkg.sv
// Shared types for the vector capture block.
//   vecrec_state_t : sweep FSM states
//   count_width()  : width of the per-sweep record counter (IW+1, holds 2^IW)
package vecrec_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSample,
      StDrain,
      StDone
   } vecrec_state_t;

   function automatic int unsigned count_width(input int unsigned iw);
      return iw + 1;
   endfunction

endpackage

// File: rtl/rec_fifo.sv
// Synchronous record FIFO.
//   clk, reset : clock, synchronous active-high reset (flushes contents)
//   push, din  : write request and data; ignored when full
//   pop        : read request; ignored when empty
//   dout       : head entry (undefined content when empty)
//   full,empty : status from the occupancy register
module rec_fifo #(
   parameter int unsigned W     = 5,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullOcc = DEPTH[AW:0];
   localparam logic [AW:0] OccOne  = 1;
   localparam logic [AW-1:0] PtrOne = 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;
   logic          push_en, pop_en;

   assign full  = (occ_q == FullOcc);
   assign empty = (occ_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   // Full/empty come from registered occupancy, so a pop never frees a slot
   // for a push in the same cycle.
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_en) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop_en)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push_en, pop_en})
         2'b10:   occ_d = occ_q + OccOne;
         2'b01:   occ_d = occ_q - OccOne;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/vector_capture.sv
// Test-vector writer: sweeps all 2^IW DUT inputs, samples the DUT output one
// settle cycle later and streams {dut_a, dut_y} records over valid/ready.
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a sweep (IDLE only)
//   dut_a      : stimulus to the DUT
//   dut_y      : DUT response
//   rec_data   : record {dut_a, dut_y}, zero when rec_valid is low
//   rec_valid  : record available
//   rec_ready  : consumer accepts the record
//   busy       : FSM not idle
//   done       : one-cycle pulse at sweep completion
//   count      : records pushed in the current sweep
module vector_capture
   import vecrec_pkg::*;
#(
   parameter int unsigned IW    = 4,
   parameter int unsigned OW    = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   output logic [IW-1:0]                 dut_a,
   input  logic [OW-1:0]                 dut_y,
   output logic [IW+OW-1:0]              rec_data,
   output logic                          rec_valid,
   input  logic                          rec_ready,
   output logic                          busy,
   output logic                          done,
   output logic [count_width(IW)-1:0]    count
);

   localparam int unsigned CW = count_width(IW);
   localparam int unsigned RW = IW + OW;
   localparam logic [CW-1:0] CountOne = 1;
   localparam logic [IW-1:0] AOne     = 1;

   vecrec_state_t state_q, state_d;
   logic [IW-1:0] dut_a_q, dut_a_d;
   logic [CW-1:0] count_q, count_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [RW-1:0] fifo_dout;

   rec_fifo #(
      .W     (RW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({dut_a_q, dut_y}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rec_valid = !fifo_empty;
   assign rec_data  = rec_valid ? fifo_dout : '0;
   assign fifo_pop  = rec_valid && rec_ready;

   assign dut_a = dut_a_q;
   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;

   always_comb begin
      state_d   = state_q;
      dut_a_d   = dut_a_q;
      count_d   = count_q;
      fifo_push = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               dut_a_d = '0;
               count_d = '0;
               state_d = StDrive;
            end
         end
         StDrive: state_d = StSample;
         StSample: begin
            if (!fifo_full) begin
               fifo_push = 1'b1;
               count_d   = count_q + CountOne;
               // Last vector holds dut_a rather than wrapping to zero.
               if (dut_a_q == '1) begin
                  state_d = StDrain;
               end else begin
                  dut_a_d = dut_a_q + AOne;
                  state_d = StDrive;
               end
            end
         end
         StDrain: begin
            if (fifo_empty) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Registered status follows the state being entered.
      busy_d = (state_d != StIdle);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         dut_a_q <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dut_a_q <= dut_a_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule
